// File: rtl/dbg_frame_pkg.sv
// Shared types and constants for the debug frame serializer.
// Optional trailing checksum byte is enabled with `define DBG_FRAME_CHECKSUM_EN.
package dbg_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int unsigned NB_ID_EX_DEF   = 144;
    localparam int unsigned NB_EX_MEM_DEF  = 32;
    localparam int unsigned NB_MEM_WB_DEF  = 40;
    localparam int unsigned NB_WB_ID_DEF   = 40;
    localparam int unsigned NB_CONTROL_DEF = 24;
    localparam logic [7:0]  HEADER_DEF     = 8'hA5;

    // Payload size in bytes for the five concatenated buses
    function automatic int unsigned payload_bytes(
        input int unsigned nb_id_ex,
        input int unsigned nb_ex_mem,
        input int unsigned nb_mem_wb,
        input int unsigned nb_wb_id,
        input int unsigned nb_control
    );
        return (nb_id_ex + nb_ex_mem + nb_mem_wb + nb_wb_id + nb_control) / 8;
    endfunction

    // Header + payload, plus one checksum byte when enabled
    function automatic int unsigned frame_bytes(
        input int unsigned pay_bytes,
        input bit          csum_en
    );
        return 1 + pay_bytes + 32'(csum_en);
    endfunction

endpackage

// File: rtl/dbg_snapshot_shreg.sv
// Parallel-load snapshot register that shifts left one byte per request,
// so the next byte to send is always the top byte.
module dbg_snapshot_shreg
    import dbg_frame_pkg::*;
#(
    parameter int unsigned NB = 280
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic          i_shift,
    input  logic [NB-1:0] i_data,
    output logic [7:0]    o_top
);

    logic [NB-1:0] sreg_q;
    logic [NB-1:0] sreg_d;

    // Load has priority over shift; otherwise hold
    always_comb begin
        sreg_d = sreg_q;
        if (i_load) begin
            sreg_d = i_data;
        end else if (i_shift) begin
            sreg_d = {sreg_q[NB-9:0], 8'h00};
        end
    end

    // Snapshot storage
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign o_top = sreg_q[NB-1 -: 8];

endmodule

// File: rtl/dbg_frame_serializer.sv
// Freezes the pipeline debug buses on a capture strobe and streams them as a
// framed byte sequence (header, payload MSB-first, optional XOR checksum) to
// uart_tx, one byte per tx_done handshake.
// Optional checksum byte: `define DBG_FRAME_CHECKSUM_EN.
module dbg_frame_serializer
    import dbg_frame_pkg::*;
#(
    parameter int unsigned NB_ID_EX   = NB_ID_EX_DEF,
    parameter int unsigned NB_EX_MEM  = NB_EX_MEM_DEF,
    parameter int unsigned NB_MEM_WB  = NB_MEM_WB_DEF,
    parameter int unsigned NB_WB_ID   = NB_WB_ID_DEF,
    parameter int unsigned NB_CONTROL = NB_CONTROL_DEF,
    parameter logic [7:0]  HEADER     = HEADER_DEF
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_capture,
    input  logic [NB_ID_EX-1:0]   i_id_ex,
    input  logic [NB_EX_MEM-1:0]  i_ex_mem,
    input  logic [NB_MEM_WB-1:0]  i_mem_wb,
    input  logic [NB_WB_ID-1:0]   i_wb_id,
    input  logic [NB_CONTROL-1:0] i_control,
    input  logic                  i_tx_done,
    output logic                  o_tx_start,
    output logic [7:0]            o_data,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_dropped
);

    localparam int unsigned NB_PAYLOAD    = NB_ID_EX + NB_EX_MEM + NB_MEM_WB + NB_WB_ID + NB_CONTROL;
    localparam int unsigned PAYLOAD_BYTES = payload_bytes(NB_ID_EX, NB_EX_MEM, NB_MEM_WB, NB_WB_ID, NB_CONTROL);
`ifdef DBG_FRAME_CHECKSUM_EN
    localparam bit          CSUM_EN       = 1'b1;
`else
    localparam bit          CSUM_EN       = 1'b0;
`endif
    localparam int unsigned FRAME_BYTES   = frame_bytes(PAYLOAD_BYTES, CSUM_EN);
    localparam int unsigned CNT_W         = $clog2(FRAME_BYTES + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         data_q, data_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               drop_q, drop_d;
`ifdef DBG_FRAME_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic               load;
    logic               shift;
    logic               is_payload;
    logic [7:0]         top_byte;

    dbg_snapshot_shreg #(
        .NB (NB_PAYLOAD)
    ) u_snapshot (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_load  (load),
        .i_shift (shift),
        .i_data  ({i_id_ex, i_ex_mem, i_mem_wb, i_wb_id, i_control}),
        .o_top   (top_byte)
    );

    // Next-state, counter, byte select and output strobes
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        start_d    = 1'b0;
        busy_d     = (state_q != IDLE);
        done_d     = 1'b0;
        drop_d     = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
`ifdef DBG_FRAME_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        // Byte index 0 is the header; payload occupies 1..PAYLOAD_BYTES
        is_payload = (cnt_q != '0) && (cnt_q <= CNT_W'(PAYLOAD_BYTES));

        case (state_q)
            IDLE: begin
                if (i_capture) begin
                    load    = 1'b1;
                    cnt_d   = '0;
`ifdef DBG_FRAME_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                    state_d = SEND;
                end
            end
            SEND: begin
                start_d = 1'b1;
                if (cnt_q == '0) begin
                    data_d = HEADER;
`ifdef DBG_FRAME_CHECKSUM_EN
                end else if (cnt_q == CNT_W'(PAYLOAD_BYTES + 1)) begin
                    data_d = csum_q;
`endif
                end else begin
                    data_d = top_byte;
                end
                state_d = WAIT;
            end
            WAIT: begin
                if (i_tx_done) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    shift = is_payload;
`ifdef DBG_FRAME_CHECKSUM_EN
                    if (is_payload) begin
                        csum_d = csum_q ^ top_byte;
                    end
`endif
                    state_d = (cnt_d == CNT_W'(FRAME_BYTES)) ? DONE : SEND;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (i_capture && (state_q != IDLE)) begin
            drop_d = 1'b1;
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

`ifdef DBG_FRAME_CHECKSUM_EN
    // Running XOR of acknowledged payload bytes
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign o_tx_start   = start_q;
    assign o_data       = data_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;
    assign o_dropped    = drop_q;

endmodule
